// File: rtl/mfp_intc_pkg.sv
// Shared constants and helpers for the mfp_intc vectored interrupt controller.
package mfp_intc_pkg;

  localparam logic [4:0] IER_OFS   = 5'h00;
  localparam logic [4:0] IPR_OFS   = 5'h04;
  localparam logic [4:0] ISR_OFS   = 5'h08;
  localparam logic [4:0] IMR_OFS   = 5'h0C;
  localparam logic [4:0] AER_OFS   = 5'h10;
  localparam logic [4:0] VR_ADDR   = 5'h14;
  localparam logic [4:0] CTRL_ADDR = 5'h15;
  localparam logic [4:0] LVL_OFS   = 5'h18;

  localparam logic [7:0] SPURIOUS_VEC = 8'h18;

  typedef logic [1:0] bank_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mfp_intc_prio.sv
// Priority finder: highest set bit of value wins; reports index, one-hot and valid.
module mfp_intc_prio
  import mfp_intc_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]        value,
  output logic [clog2(N)-1:0] index,
  output logic [N-1:0]        onehot,
  output logic                valid
);
  localparam int W = clog2(N);

  always_comb begin
    index  = '0;
    onehot = '0;
    valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (value[i]) begin
        index     = i[W-1:0];
        onehot    = '0;
        onehot[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mfp_intc.sv
// MFP-style vectored interrupt controller with N_SRC sources and 68000 IACK vectoring.
// Define MFP_INTC_LEVEL_EN to add the per-source LVL (level-sensitive) registers.
module mfp_intc
  import mfp_intc_pkg::*;
#(
  parameter int N_SRC       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             sel,
  input  logic             ds,
  input  logic             rw,
  input  logic [4:0]       addr,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             dtack,
  output logic             irq,
  input  logic             iack,
  input  logic [N_SRC-1:0] src_i
);
  localparam int NB    = N_SRC / 8;
  localparam int IDX_W = clog2(N_SRC);

  logic [N_SRC-1:0] ier, ipr, isr, imr, aer, lvl;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] s, s_prev, edge_det, lvl_val, ipr_clr, isr_clr, ipr_n, isr_n;
  logic [N_SRC-1:0] pend, bmask, wdat, p_oh, isr_oh_unused;
  logic [IDX_W-1:0] p_idx, s_idx;
  logic [7:0]       vr, vec, rdata;
  logic [4:0]       grp;
  bank_t            bank;
  logic seoi, bus_q, iack_q, irq_n, p_vld, s_vld;
  logic bus_sel, wr_stb, iack_stb, iack_take;
  logic wr_ier, wr_ipr, wr_isr, wr_imr, wr_aer, wr_vr, wr_ctrl;

  function automatic logic [N_SRC-1:0] merge(input logic [N_SRC-1:0] old_v, m, d);
    return (old_v & ~m) | (d & m);
  endfunction

  // Banks past N_SRC/8 shift out to zero, so no explicit range check is needed.
  function automatic logic [7:0] bank_byte(input logic [N_SRC-1:0] v, input bank_t b);
    logic [N_SRC-1:0] t;
    t = v >> (8 * int'(b));
    return t[7:0];
  endfunction

  assign bus_sel   = sel & ~ds;
  assign bank      = addr[1:0];
  assign grp       = {addr[4:2], 2'b00};
  assign wdat      = {NB{din}};
  assign wr_stb    = clk_en & bus_sel & ~bus_q & ~rw;
  assign iack_stb  = clk_en & iack & ~iack_q;
  assign iack_take = iack_stb & p_vld;

  always_comb begin
    bmask = '0;
    for (int b = 0; b < NB; b++)
      if (int'(bank) == b) bmask[8*b +: 8] = 8'hFF;
  end

  assign wr_ier  = wr_stb & (grp == IER_OFS);
  assign wr_ipr  = wr_stb & (grp == IPR_OFS);
  assign wr_isr  = wr_stb & (grp == ISR_OFS);
  assign wr_imr  = wr_stb & (grp == IMR_OFS);
  assign wr_aer  = wr_stb & (grp == AER_OFS);
  assign wr_vr   = wr_stb & (addr == VR_ADDR);
  assign wr_ctrl = wr_stb & (addr == CTRL_ADDR);

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = (s ^ s_prev) & ~(s ^ aer) & ~lvl;
  assign lvl_val  = ~(s ^ aer) & ier;
  assign pend     = ipr & imr;

  mfp_intc_prio #(.N(N_SRC)) u_pend_prio (
    .value(pend), .index(p_idx), .onehot(p_oh), .valid(p_vld)
  );
  mfp_intc_prio #(.N(N_SRC)) u_isr_prio (
    .value(isr), .index(s_idx), .onehot(isr_oh_unused), .valid(s_vld)
  );

  // Edge set is OR-ed in after the clear so a coincident edge is never lost.
  assign ipr_clr = ({N_SRC{wr_ipr | wr_ier}} & bmask & ~wdat) | ({N_SRC{iack_take}} & p_oh);
  assign ipr_n   = (((ipr & ~ipr_clr) | (edge_det & ier)) & ~lvl) | (lvl_val & lvl);
  assign isr_clr = ({N_SRC{wr_isr}} & bmask & ~wdat) | {N_SRC{wr_ctrl & ~din[0]}};
  assign isr_n   = (isr & ~isr_clr) | ({N_SRC{iack_take & seoi}} & p_oh);
  assign irq_n   = p_vld & (~s_vld | (p_idx > s_idx));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_prev <= '0;
      ier    <= '0;
      ipr    <= '0;
      isr    <= '0;
      imr    <= '0;
      aer    <= '0;
      vr     <= '0;
      seoi   <= 1'b0;
      vec    <= '0;
      bus_q  <= 1'b0;
      iack_q <= 1'b0;
      dtack  <= 1'b0;
      irq    <= 1'b0;
    end else begin
      sync_q[0] <= src_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_prev <= s;
      if (wr_ier) ier <= merge(ier, bmask, wdat);
      if (wr_imr) imr <= merge(imr, bmask, wdat);
      if (wr_aer) aer <= merge(aer, bmask, wdat);
      if (wr_vr) vr <= din;
      if (wr_ctrl) seoi <= din[0];
      ipr <= ipr_n;
      isr <= isr_n;
      irq <= irq_n;
      if (clk_en) begin
        bus_q  <= bus_sel;
        iack_q <= iack;
        dtack  <= (bus_sel & bus_q) | (iack & iack_q);
        if (iack_stb) vec <= p_vld ? {vr[7:IDX_W], p_idx} : SPURIOUS_VEC;
      end
    end
  end

`ifdef MFP_INTC_LEVEL_EN
  logic wr_lvl;
  assign wr_lvl = wr_stb & (grp == LVL_OFS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lvl <= '0;
    else if (wr_lvl) lvl <= merge(lvl, bmask, wdat);
  end
`else
  assign lvl = '0;
`endif

  always_comb begin
    rdata = '0;
    case (grp)
      IER_OFS: rdata = bank_byte(ier, bank);
      IPR_OFS: rdata = bank_byte(ipr, bank);
      ISR_OFS: rdata = bank_byte(isr, bank);
      IMR_OFS: rdata = bank_byte(imr, bank);
      AER_OFS: rdata = bank_byte(aer, bank);
      VR_ADDR: begin
        if (addr == VR_ADDR) rdata = vr;
        else if (addr == CTRL_ADDR) rdata = {7'b0, seoi};
      end
      LVL_OFS: rdata = bank_byte(lvl, bank);
      default: rdata = '0;
    endcase
  end

  assign dout = (bus_sel & rw) ? rdata : (iack ? vec : 8'h00);

endmodule

// File: tb/tb_mfp_intc.sv
// Bench for mfp_intc: register table, directed IRQ/IACK sequences and a randomized model check.
module tb_mfp_intc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        ds = 1'b1, rw = 1'b0;
  logic        sel_a = 1'b0, sel_b = 1'b0, iack_a = 1'b0, iack_b = 1'b0;
  logic [4:0]  addr = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout_a, dout_b;
  logic        dtack_a, dtack_b, irq_a, irq_b;
  logic [15:0] src_a = '0;
  logic [31:0] src_b = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mfp_intc #(.N_SRC(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .clk_en(clk_en), .sel(sel_a), .ds(ds), .rw(rw),
    .addr(addr), .din(din), .dout(dout_a), .dtack(dtack_a), .irq(irq_a),
    .iack(iack_a), .src_i(src_a)
  );

  mfp_intc #(.N_SRC(32), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .clk_en(clk_en), .sel(sel_b), .ds(ds), .rw(rw),
    .addr(addr), .din(din), .dout(dout_b), .dtack(dtack_b), .irq(irq_b),
    .iack(iack_b), .src_i(src_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  function automatic logic cur_dtack(input bit u);
    return u ? dtack_b : dtack_a;
  endfunction

  function automatic logic [7:0] cur_dout(input bit u);
    return u ? dout_b : dout_a;
  endfunction

  task automatic wait_dtack(input bit u, input logic lvl, input string nm);
    int n = 0;
    while (cur_dtack(u) !== lvl && n < 20) begin
      step();
      n++;
    end
    if (cur_dtack(u) !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: dtack stuck at %0b, wanted %0b", nm, cur_dtack(u), lvl);
    end
  endtask

  task automatic bus_write(input bit u, input logic [4:0] a, input logic [7:0] d);
    addr = a; din = d; rw = 1'b0; ds = 1'b0;
    if (u) sel_b = 1'b1; else sel_a = 1'b1;
    step();
    wait_dtack(u, 1'b1, "wr_dtack_rise");
    sel_a = 1'b0; sel_b = 1'b0; ds = 1'b1;
    wait_dtack(u, 1'b0, "wr_dtack_fall");
  endtask

  task automatic bus_read(input bit u, input logic [4:0] a, output logic [7:0] d);
    addr = a; rw = 1'b1; ds = 1'b0;
    if (u) sel_b = 1'b1; else sel_a = 1'b1;
    step();
    wait_dtack(u, 1'b1, "rd_dtack_rise");
    d = cur_dout(u);
    sel_a = 1'b0; sel_b = 1'b0; ds = 1'b1; rw = 1'b0;
    wait_dtack(u, 1'b0, "rd_dtack_fall");
  endtask

  task automatic iack_cycle(input bit u, output logic [7:0] v);
    if (u) iack_b = 1'b1; else iack_a = 1'b1;
    step();
    wait_dtack(u, 1'b1, "iack_dtack_rise");
    v = cur_dout(u);
    iack_a = 1'b0; iack_b = 1'b0;
    wait_dtack(u, 1'b0, "iack_dtack_fall");
  endtask

  task automatic read_check(input bit u, input logic [4:0] a, input logic [7:0] e, input string nm);
    logic [7:0] d;
    bus_read(u, a, d);
    check(nm, d, e);
  endtask

  task automatic do_reset();
    src_a = '0; src_b = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle(4);
  endtask

  // Reference model helpers
  function automatic int hi16(input bit [15:0] v);
    int r = -1;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {
    logic [4:0] a;
    logic [7:0] w;
    logic [7:0] e;
  } reg_vec_t;

  reg_vec_t tbl[12];

  bit [15:0] m_ier, m_ipr, m_isr, m_imr, m_aer;
  bit [7:0]  m_vr;
  bit        m_seoi;

  initial begin
    logic [7:0] v;
    logic [7:0] lvl_exp;
`ifdef MFP_INTC_LEVEL_EN
    lvl_exp = 8'h0F;
`else
    lvl_exp = 8'h00;
`endif
    tbl[0]  = '{5'h00, 8'hA5, 8'hA5};
    tbl[1]  = '{5'h01, 8'h3C, 8'h3C};
    tbl[2]  = '{5'h02, 8'hFF, 8'h00};
    tbl[3]  = '{5'h0C, 8'h5A, 8'h5A};
    tbl[4]  = '{5'h11, 8'h81, 8'h81};
    tbl[5]  = '{5'h04, 8'hFF, 8'h00};
    tbl[6]  = '{5'h09, 8'hFF, 8'h00};
    tbl[7]  = '{5'h14, 8'h7E, 8'h7E};
    tbl[8]  = '{5'h15, 8'hFF, 8'h01};
    tbl[9]  = '{5'h16, 8'hFF, 8'h00};
    tbl[10] = '{5'h0F, 8'h77, 8'h00};
    tbl[11] = '{5'h18, 8'h0F, lvl_exp};

    // Reset state
    #1;
    check("reset_irq", irq_a, 1'b0);
    check("reset_dtack", dtack_a, 1'b0);
    check("reset_dout", dout_a, 8'h00);
    check("reset_irq_b", irq_b, 1'b0);
    settle(2);
    reset = 1'b0;
    settle(2);
    read_check(0, 5'h00, 8'h00, "reset_ier0");
    read_check(0, 5'h15, 8'h00, "reset_ctrl");

    // Register write/readback table
    for (int i = 0; i < 12; i++) begin
      bus_write(0, tbl[i].a, tbl[i].w);
      bus_read(0, tbl[i].a, v);
      check($sformatf("table_%0d_addr_%0h", i, tbl[i].a), v, tbl[i].e);
    end
    do_reset();

    // Falling edge on src 5, SEOI vectoring
    bus_write(0, 5'h00, 8'h20);
    bus_write(0, 5'h0C, 8'h20);
    bus_write(0, 5'h10, 8'h00);
    bus_write(0, 5'h14, 8'h40);
    bus_write(0, 5'h15, 8'h01);
    src_a[5] = 1'b1; settle(5);
    check("rise_no_irq", irq_a, 1'b0);
    src_a[5] = 1'b0; settle(5);
    read_check(0, 5'h04, 8'h20, "t1_ipr");
    check("t1_irq", irq_a, 1'b1);
    iack_cycle(0, v);
    check("t1_vector", v, 8'h45);
    read_check(0, 5'h04, 8'h00, "t1_ipr_cleared");
    read_check(0, 5'h08, 8'h20, "t1_isr_set");
    check("t1_irq_low", irq_a, 1'b0);

    // In-service blocks lower priority, higher one preempts
    bus_write(0, 5'h00, 8'h28);
    bus_write(0, 5'h0C, 8'h28);
    bus_write(0, 5'h01, 8'h02);
    bus_write(0, 5'h0D, 8'h02);
    src_a[3] = 1'b1; src_a[9] = 1'b1; settle(5);
    src_a[3] = 1'b0; settle(5);
    check("t2_lower_blocked", irq_a, 1'b0);
    src_a[9] = 1'b0; settle(5);
    check("t2_higher_irq", irq_a, 1'b1);
    iack_cycle(0, v);
    check("t2_vector", v, 8'h49);
    bus_write(0, 5'h08, 8'hDF);
    read_check(0, 5'h08, 8'h00, "t2_isr0_cleared");
    read_check(0, 5'h09, 8'h02, "t2_isr1_kept");
    check("t2_irq_under_isr9", irq_a, 1'b0);
    bus_write(0, 5'h09, 8'h00);
    settle(2);
    check("t2_irq_after_eoi", irq_a, 1'b1);

    // Mask everything: spurious vector, no state change
    bus_write(0, 5'h0C, 8'h00);
    bus_write(0, 5'h0D, 8'h00);
    settle(2);
    check("t3_irq_masked", irq_a, 1'b0);
    iack_cycle(0, v);
    check("t3_spurious", v, 8'h18);
    read_check(0, 5'h04, 8'h08, "t3_ipr_kept");
    read_check(0, 5'h08, 8'h00, "t3_isr_kept");

    // Clear write coinciding with a new edge
    bus_write(0, 5'h04, 8'h00);
    bus_write(0, 5'h00, 8'h04);
    src_a[2] = 1'b1; settle(5);
    read_check(0, 5'h04, 8'h00, "t4_rise_ignored");
    src_a[2] = 1'b0;
    step(); step();
    bus_write(0, 5'h04, 8'h00);
    read_check(0, 5'h04, 8'h04, "t4_set_beats_clear");
    bus_write(0, 5'h00, 8'h00);
    read_check(0, 5'h04, 8'h00, "t4_ier_disable_clears");

    // 32 sources, rising edge on top source, auto-EOI
    bus_write(1, 5'h03, 8'h80);
    bus_write(1, 5'h0F, 8'h80);
    bus_write(1, 5'h13, 8'h80);
    bus_write(1, 5'h14, 8'h80);
    src_b[31] = 1'b1; settle(5);
    check("t5_irq", irq_b, 1'b1);
    iack_cycle(1, v);
    check("t5_vector", v, 8'h9F);
    read_check(1, 5'h07, 8'h00, "t5_ipr3_cleared");
    read_check(1, 5'h0B, 8'h00, "t5_isr3_autoeoi");
    read_check(1, 5'h03, 8'h80, "t5_ier3");
    read_check(1, 5'h13, 8'h80, "t5_aer3");
    read_check(1, 5'h17, 8'h00, "t5_reserved");
    check("t5_irq_low", irq_b, 1'b0);

    // No bus activity while clk_en is low
    clk_en = 1'b0;
    addr = 5'h0C; din = 8'hAA; rw = 1'b0; ds = 1'b0; sel_a = 1'b1;
    settle(4);
    check("clk_en_no_dtack", dtack_a, 1'b0);
    sel_a = 1'b0; ds = 1'b1;
    settle(1);
    clk_en = 1'b1;
    settle(2);
    read_check(0, 5'h0C, 8'h00, "clk_en_no_write");

    // Asynchronous reset in the middle of a read
    bus_write(0, 5'h00, 8'h55);
    addr = 5'h00; rw = 1'b1; ds = 1'b0; sel_a = 1'b1;
    step(); step();
    check("async_pre_dtack", dtack_a, 1'b1);
    check("async_pre_dout", dout_a, 8'h55);
    #3;
    reset = 1'b1;
    #1;
    check("async_dtack_drop", dtack_a, 1'b0);
    check("async_dout_clear", dout_a, 8'h00);
    sel_a = 1'b0; ds = 1'b1; rw = 1'b0;
    step();
    reset = 1'b0;
    settle(4);

`ifdef MFP_INTC_LEVEL_EN
    // Level-sensitive source 0
    bus_write(0, 5'h18, 8'h01);
    bus_write(0, 5'h10, 8'h01);
    bus_write(0, 5'h00, 8'h01);
    bus_write(0, 5'h0C, 8'h01);
    bus_write(0, 5'h14, 8'h40);
    bus_write(0, 5'h15, 8'h01);
    src_a[0] = 1'b1; settle(5);
    read_check(0, 5'h04, 8'h01, "lvl_ipr");
    iack_cycle(0, v);
    check("lvl_vector", v, 8'h40);
    read_check(0, 5'h04, 8'h01, "lvl_ipr_reasserts");
    read_check(0, 5'h08, 8'h01, "lvl_isr");
    src_a[0] = 1'b0; settle(3);
    read_check(0, 5'h04, 8'h00, "lvl_ipr_drop");
    do_reset();
`endif

    // Randomized sequence against the transaction-level model
    do_reset();
    m_ier = '0; m_ipr = '0; m_isr = '0; m_imr = '0; m_aer = '0; m_vr = '0; m_seoi = 1'b0;
    for (int it = 0; it < 200; it++) begin
      int op, k, b, p, sidx;
      logic [7:0] d, ev;
      logic [4:0] a;
      bit [15:0] mask, nsrc;
      bit exp_irq;
      op = $urandom_range(0, 5);
      if (op == 0) begin
        k = $urandom_range(0, 6);
        b = $urandom_range(0, 1);
        d = 8'($urandom_range(0, 255));
        a = (k < 5) ? 5'(4 * k + b) : ((k == 5) ? 5'h14 : 5'h15);
        case (k)
          0: begin m_ier[8*b +: 8] = d; m_ipr[8*b +: 8] = m_ipr[8*b +: 8] & d; end
          1: m_ipr[8*b +: 8] = m_ipr[8*b +: 8] & d;
          2: m_isr[8*b +: 8] = m_isr[8*b +: 8] & d;
          3: m_imr[8*b +: 8] = d;
          4: m_aer[8*b +: 8] = d;
          5: m_vr = d;
          default: begin m_seoi = d[0]; if (!d[0]) m_isr = '0; end
        endcase
        bus_write(0, a, d);
      end else if (op <= 2) begin
        mask = '0;
        mask[$urandom_range(0, 15)] = 1'b1;
        mask[$urandom_range(0, 15)] = 1'b1;
        nsrc = src_a ^ mask;
        for (int i = 0; i < 16; i++)
          if (mask[i] && nsrc[i] == m_aer[i] && m_ier[i]) m_ipr[i] = 1'b1;
        src_a = nsrc;
        settle(5);
      end else if (op == 3) begin
        p = hi16(m_ipr & m_imr);
        if (p >= 0) begin
          ev = (m_vr & 8'hF0) | 8'(p);
          m_ipr[p] = 1'b0;
          if (m_seoi) m_isr[p] = 1'b1;
        end else begin
          ev = 8'h18;
        end
        iack_cycle(0, v);
        check($sformatf("rand_%0d_vector", it), v, ev);
      end else begin
        k = $urandom_range(0, 4);
        b = $urandom_range(0, 1);
        case (k)
          0: ev = m_ier[8*b +: 8];
          1: ev = m_ipr[8*b +: 8];
          2: ev = m_isr[8*b +: 8];
          3: ev = m_imr[8*b +: 8];
          default: ev = m_aer[8*b +: 8];
        endcase
        read_check(0, 5'(4 * k + b), ev, $sformatf("rand_%0d_read_%0d_%0d", it, k, b));
      end
      settle(2);
      p = hi16(m_ipr & m_imr);
      sidx = hi16(m_isr);
      exp_irq = (p >= 0) && (sidx < 0 || p > sidx);
      check($sformatf("rand_%0d_irq", it), irq_a, exp_irq);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
